mc_frame_arbiter: RTL and testbench
===================================

Name: mc_frame_arbiter

Overview:
- Frame-level round-robin arbiter and sequencer that shares one MC convolution pipeline (FFT_256 -> MULT -> IFFT_256) between NUM_REQ requesters.
- MC needs contiguous FRAME_LEN-cycle in_valid bursts of x_real plus delta, and returns contiguous FRAME_LEN-cycle out_valid frames in issue order.
- The block grants whole frames, muxes requester samples into MC, and tags each issued frame in an in-order tag FIFO.
- It routes each returned frame to its requester ID with a last-sample marker.

Parameters:
- NUM_REQ, 2, number of requesters (>=2).
- FRAME_LEN, 256, samples per frame; must match the MC transform size.
- MAX_OUT, 4, maximum frames in flight (tag FIFO depth, power of 2).
- GAP_CYCLES, 0, minimum idle cycles forced between consecutive input bursts.
- ID_W, 1, requester ID width, equal to $clog2(NUM_REQ).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- req_valid  in  NUM_REQ  requester i has a frame pending; held high until its grant burst ends.
- req_x_real  in  16*NUM_REQ  signed sample of requester i, slice [16i+15:16i].
- req_delta_real  in  16*NUM_REQ  signed delta real per requester.
- req_delta_img  in  16*NUM_REQ  signed delta imag per requester.
- req_grant  out  NUM_REQ  one-hot; high for exactly FRAME_LEN consecutive cycles; requester presents sample k on the k-th grant cycle.
- mc_in_valid  out  1  to MC in_valid.
- mc_x_real  out  16  to MC x_real.
- mc_delta_real  out  16  to MC delta_real.
- mc_delta_img  out  16  to MC delta_img.
- mc_out_valid  in  1  from MC out_valid.
- mc_y_real  in  16  from MC y_real.
- mc_y_img  in  16  from MC y_img.
- rsp_valid  out  1  routed result sample valid.
- rsp_id  out  ID_W  owner of the current result frame.
- rsp_y_real  out  16  result real part.
- rsp_y_img  out  16  result imag part.
- rsp_last  out  1  last sample of the frame.
- outstanding  out  $clog2(MAX_OUT)+1  frames issued but not fully returned.
- err_orphan  out  1  sticky: MC output arrived with the tag FIFO empty.
- err_proto  out  1  sticky: req_valid of the granted requester dropped mid-burst.

Behaviour:
- Reset: all outputs are 0, the FSM is in IDLE, the round-robin pointer is 0, the tag FIFO is empty, counters are 0, and sticky errors are cleared.
  - Reset mid-burst or mid-response aborts immediately; no partial frame is resumed.
  - MC shares rst_n, so it is flushed at the same time.
- FSM IDLE:
  - If any req_valid is high and the FIFO is not full, pick the first requesting index at or after rr_ptr (wrapping).
  - Push its ID into the tag FIFO, set sel, go to BURST, set in_cnt to 0, and set rr_ptr to sel+1 mod NUM_REQ.
  - If the FIFO is full, stay in IDLE; req_grant stays 0.
- FSM BURST:
  - req_grant[sel] is 1 (registered, asserted the cycle after the IDLE decision).
  - Each cycle, register requester sel's x and delta onto mc_*; mc_in_valid=1, so MC sees the sample one cycle after the grant cycle.
  - in_cnt increments. At in_cnt==FRAME_LEN-1, go to GAP if GAP_CYCLES>0, else IDLE.
  - Back-to-back is allowed when GAP_CYCLES=0: one IDLE decision cycle yields a 1-cycle bubble.
  - If req_valid[sel] is low during BURST, set err_proto; the burst continues to completion.
- FSM GAP: count GAP_CYCLES cycles with mc_in_valid=0, then go to IDLE.
- When mc_in_valid=0, all mc_* data outputs are 0.
- Response path:
  - Registered 1-cycle: the rsp_* signals follow mc_out_valid and mc_y_* one cycle later.
  - out_cnt counts valid MC samples. On out_cnt==0 with mc_out_valid, pop the tag FIFO and hold the popped ID as rsp_id for the frame.
  - rsp_last=1 with the sample where out_cnt==FRAME_LEN-1; out_cnt then wraps to 0.
  - A gap in mc_out_valid mid-frame holds out_cnt and rsp_id; the frame resumes.
- Orphan output: mc_out_valid at out_cnt==0 with the FIFO empty sets err_orphan.
  - The whole frame is dropped: rsp_valid stays 0 for those FRAME_LEN samples.
- Occupancy: outstanding increments on push and decrements when a frame's last sample is forwarded.
  - A simultaneous push and pop leaves it unchanged.
  - FIFO full means outstanding==MAX_OUT, which blocks new grants.
- Arithmetic: the block performs none; data passes through unmodified, signed 16-bit.

Decomposition:
- Package mc_pkg holds FRAME_LEN, the CNT_W=$clog2(FRAME_LEN) constant, and the FSM state enum (IDLE, BURST, GAP).
- One sub-module: mc_tag_fifo, a synchronous FIFO of depth MAX_OUT and width ID_W with push/pop/full/empty and simultaneous push+pop.

Test Plan:
- Single frame from req0 (x=k, delta=0x1000):
  - grant[0] is high for 256 cycles.
  - mc_in_valid is high for 256 cycles, lagging the grant by 1 cycle; mc_x_real follows 0..255.
  - After MC returns, rsp_id=0 for 256 samples and rsp_last is on the 256th.
- req0 and req1 both asserted at reset release: grants go to 0 then 1 with a 1-cycle bubble; returned frames have rsp_id 0 then 1; outstanding peaks at 2.
- MAX_OUT=2, three back-to-back frames from req1: the third grant is withheld until the first result frame's rsp_last, then issues.
- GAP_CYCLES=3, continuous requests: exactly 4 idle cycles separate bursts (3 GAP plus 1 IDLE decision).
- Force mc_out_valid for 256 cycles with no frame issued: err_orphan=1, rsp_valid stays 0, outstanding=0.
- Assert rst_n=0 at in_cnt=100 of a burst: the next cycle has req_grant=0 and mc_in_valid=0, and outstanding=0. A subsequent request restarts from rr_ptr=0.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared constants and FSM encoding for the MC frame arbiter.
package mc_pkg;
  localparam int FRAME_LEN = 256;
  localparam int CNT_W     = $clog2(FRAME_LEN);

  typedef enum logic [1:0] {IDLE, BURST, GAP} arb_state_t;
endpackage

// File: rtl/mc_tag_fifo.sv
// In-order tag FIFO: records the owner of each frame issued to MC.
module mc_tag_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr, rd_ptr;
  logic         do_push, do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  // a pop in the same cycle frees the slot the push needs
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end
endmodule

// File: rtl/mc_frame_arbiter.sv
// Frame-granular round-robin sharing of one MC pipeline; routes returned
// frames back to their requesters in issue order.
module mc_frame_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int FRAME_LEN  = 256,
  parameter int MAX_OUT    = 4,
  parameter int GAP_CYCLES = 0,
  parameter int ID_W       = $clog2(NUM_REQ)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [16*NUM_REQ-1:0]      req_x_real,
  input  logic [16*NUM_REQ-1:0]      req_delta_real,
  input  logic [16*NUM_REQ-1:0]      req_delta_img,
  output logic [NUM_REQ-1:0]         req_grant,
  output logic                       mc_in_valid,
  output logic [15:0]                mc_x_real,
  output logic [15:0]                mc_delta_real,
  output logic [15:0]                mc_delta_img,
  input  logic                       mc_out_valid,
  input  logic [15:0]                mc_y_real,
  input  logic [15:0]                mc_y_img,
  output logic                       rsp_valid,
  output logic [ID_W-1:0]            rsp_id,
  output logic [15:0]                rsp_y_real,
  output logic [15:0]                rsp_y_img,
  output logic                       rsp_last,
  output logic [$clog2(MAX_OUT):0]   outstanding,
  output logic                       err_orphan,
  output logic                       err_proto
);
  import mc_pkg::*;

  localparam int CW    = $clog2(FRAME_LEN);
  localparam int OUT_W = $clog2(MAX_OUT) + 1;
  localparam int GW    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  logic [NUM_REQ-1:0][15:0] x_arr, dr_arr, di_arr;
  assign x_arr  = req_x_real;
  assign dr_arr = req_delta_real;
  assign di_arr = req_delta_img;

  arb_state_t      state;
  logic [ID_W-1:0] sel, rr_ptr, pick, tag_dout, rsp_tag;
  logic [CW-1:0]   in_cnt, out_cnt;
  logic [GW-1:0]   gap_cnt;
  logic            pick_vld, push, pop, fifo_full, fifo_empty;
  logic            first, drop_q, frame_drop, fwd, fwd_last;

  // lowest requester at or after rr_ptr wins, else lowest overall
  always_comb begin
    pick_vld = |req_valid;
    pick     = '0;
    for (int j = NUM_REQ-1; j >= 0; j--)
      if (req_valid[j]) pick = ID_W'(j);
    for (int j = NUM_REQ-1; j >= 0; j--)
      if (req_valid[j] && j >= int'(rr_ptr)) pick = ID_W'(j);
  end

  // in-flight limit counts frames until their last sample is forwarded
  assign push = (state == IDLE) && pick_vld && !fifo_full &&
                (outstanding != OUT_W'(MAX_OUT));

  assign first      = (out_cnt == '0);
  assign pop        = mc_out_valid && first && !fifo_empty;
  assign frame_drop = first ? fifo_empty : drop_q;
  assign fwd        = mc_out_valid && !frame_drop;
  assign fwd_last   = fwd && (out_cnt == CW'(FRAME_LEN-1));
  assign rsp_tag    = first ? tag_dout : rsp_id;

  mc_tag_fifo #(.DEPTH(MAX_OUT), .W(ID_W)) u_tag_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (pick),
    .pop   (pop),
    .dout  (tag_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      sel           <= '0;
      rr_ptr        <= '0;
      in_cnt        <= '0;
      gap_cnt       <= '0;
      req_grant     <= '0;
      mc_in_valid   <= 1'b0;
      mc_x_real     <= '0;
      mc_delta_real <= '0;
      mc_delta_img  <= '0;
      err_proto     <= 1'b0;
    end else begin
      mc_in_valid   <= 1'b0;
      mc_x_real     <= '0;
      mc_delta_real <= '0;
      mc_delta_img  <= '0;
      unique case (state)
        IDLE: if (push) begin
          sel       <= pick;
          rr_ptr    <= (int'(pick) == NUM_REQ-1) ? '0 : pick + 1'b1;
          in_cnt    <= '0;
          req_grant <= NUM_REQ'(1) << pick;
          state     <= BURST;
        end
        BURST: begin
          mc_in_valid   <= 1'b1;
          mc_x_real     <= x_arr[sel];
          mc_delta_real <= dr_arr[sel];
          mc_delta_img  <= di_arr[sel];
          if (!req_valid[sel]) err_proto <= 1'b1;
          in_cnt <= in_cnt + 1'b1;
          if (in_cnt == CW'(FRAME_LEN-1)) begin
            req_grant <= '0;
            gap_cnt   <= '0;
            state     <= (GAP_CYCLES > 0) ? GAP : IDLE;
          end
        end
        GAP: begin
          gap_cnt <= gap_cnt + 1'b1;
          if (gap_cnt == GW'(GAP_CYCLES-1)) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_cnt     <= '0;
      drop_q      <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_id      <= '0;
      rsp_y_real  <= '0;
      rsp_y_img   <= '0;
      rsp_last    <= 1'b0;
      err_orphan  <= 1'b0;
      outstanding <= '0;
    end else begin
      rsp_valid  <= fwd;
      rsp_last   <= fwd_last;
      rsp_y_real <= fwd ? mc_y_real : '0;
      rsp_y_img  <= fwd ? mc_y_img  : '0;
      if (fwd) rsp_id <= rsp_tag;
      if (mc_out_valid) begin
        out_cnt <= (out_cnt == CW'(FRAME_LEN-1)) ? '0 : out_cnt + 1'b1;
        // an untagged frame is swallowed whole
        if (first) begin
          drop_q <= fifo_empty;
          if (fifo_empty) err_orphan <= 1'b1;
        end
      end
      case ({push, fwd_last})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mc_frame_arbiter.sv
// Directed bench for mc_frame_arbiter: a GAP_CYCLES=0/MAX_OUT=2 instance plus
// a GAP_CYCLES=3 instance for burst spacing.
module tb_mc_frame_arbiter;
  localparam int NR = 2;
  localparam int FL = 256;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic              rst_n;
  logic [NR-1:0]     req_valid, g_req_valid;
  logic [16*NR-1:0]  req_x_real, req_delta_real, req_delta_img;
  logic [NR-1:0]     req_grant, g_grant;
  logic              mc_in_valid, mc_out_valid;
  logic [15:0]       mc_x_real, mc_delta_real, mc_delta_img, mc_y_real, mc_y_img;
  logic              rsp_valid, rsp_last, err_orphan, err_proto;
  logic [0:0]        rsp_id;
  logic [15:0]       rsp_y_real, rsp_y_img;
  logic [1:0]        outstanding;
  logic              g_in_valid, g_rsp_valid, g_rsp_last, g_err_orphan, g_err_proto;
  logic [15:0]       g_x, g_dr, g_di, g_yr, g_yi;
  logic [0:0]        g_rsp_id;
  logic [2:0]        g_out;

  mc_frame_arbiter #(.NUM_REQ(NR), .FRAME_LEN(FL), .MAX_OUT(2), .GAP_CYCLES(0), .ID_W(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_x_real(req_x_real),
    .req_delta_real(req_delta_real), .req_delta_img(req_delta_img), .req_grant(req_grant),
    .mc_in_valid(mc_in_valid), .mc_x_real(mc_x_real), .mc_delta_real(mc_delta_real),
    .mc_delta_img(mc_delta_img), .mc_out_valid(mc_out_valid), .mc_y_real(mc_y_real),
    .mc_y_img(mc_y_img), .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_y_real(rsp_y_real),
    .rsp_y_img(rsp_y_img), .rsp_last(rsp_last), .outstanding(outstanding),
    .err_orphan(err_orphan), .err_proto(err_proto));

  mc_frame_arbiter #(.NUM_REQ(NR), .FRAME_LEN(FL), .MAX_OUT(4), .GAP_CYCLES(3), .ID_W(1)) u_gap (
    .clk(clk), .rst_n(rst_n), .req_valid(g_req_valid), .req_x_real(req_x_real),
    .req_delta_real(req_delta_real), .req_delta_img(req_delta_img), .req_grant(g_grant),
    .mc_in_valid(g_in_valid), .mc_x_real(g_x), .mc_delta_real(g_dr),
    .mc_delta_img(g_di), .mc_out_valid(1'b0), .mc_y_real(16'd0),
    .mc_y_img(16'd0), .rsp_valid(g_rsp_valid), .rsp_id(g_rsp_id), .rsp_y_real(g_yr),
    .rsp_y_img(g_yi), .rsp_last(g_rsp_last), .outstanding(g_out),
    .err_orphan(g_err_orphan), .err_proto(g_err_proto));

  int n_chk = 0, n_pass = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // MC stand-in: one contiguous result frame, y_real = k + 0x4000, y_img = ~k
  task automatic mc_frame();
    for (int k = 0; k < FL; k++) begin
      mc_out_valid = 1'b1;
      mc_y_real    = 16'(k) + 16'h4000;
      mc_y_img     = ~16'(k);
      @(negedge clk);
    end
    mc_out_valid = 1'b0;
    mc_y_real    = '0;
    mc_y_img     = '0;
  endtask

  // requesters: present sample k on the k-th grant cycle, drop valid after the burst
  int gcnt [NR];
  int frames_left [NR];
  initial begin
    req_valid = '0; req_x_real = '0; req_delta_real = '0; req_delta_img = '0;
    for (int i = 0; i < NR; i++) begin gcnt[i] = 0; frames_left[i] = 0; end
    forever begin
      @(negedge clk);
      for (int i = 0; i < NR; i++) begin
        if (req_grant[i]) begin
          req_x_real[16*i +: 16]     = 16'(gcnt[i]);
          req_delta_real[16*i +: 16] = 16'h1000;
          req_delta_img[16*i +: 16]  = 16'(i + 1);
          gcnt[i]++;
        end else if (gcnt[i] > 0) begin
          gcnt[i] = 0;
          if (frames_left[i] > 0) frames_left[i]--;
        end
        req_valid[i] = (frames_left[i] > 0);
      end
    end
  end

  // observation of u_dut grants, MC input stream and responses
  int own_q[$], glen_q[$], gidle_q[$], grise_q[$];
  int vlen_q[$], vrise_q[$], rid_q[$], rlen_q[$], rlast_q[$];
  int g_rise = 0, g_fall = -1, v_rise = 0, vpos = 0, rpos = 0;
  int in_err = 0, zero_err = 0, r_err = 0, r_cnt = 0, out_peak = 0, onehot_err = 0;
  logic [NR-1:0] pg = '0;
  logic pv = 1'b0;
  initial forever begin
    @(negedge clk);
    if (!rst_n) g_fall = -1;
    if (req_grant != '0 && pg == '0) begin
      own_q.push_back(req_grant[1] ? 1 : 0);
      grise_q.push_back(cyc);
      if (g_fall >= 0) gidle_q.push_back(cyc - g_fall);
      g_rise = cyc;
    end
    if (req_grant == '0 && pg != '0) begin
      glen_q.push_back(cyc - g_rise);
      g_fall = cyc;
    end
    if (req_grant == 2'b11) onehot_err++;
    pg = req_grant;
    if (mc_in_valid) begin
      if (!pv) begin vrise_q.push_back(cyc); v_rise = cyc; vpos = 0; end
      if (mc_x_real != 16'(vpos) || mc_delta_real != 16'h1000) in_err++;
      if (own_q.size() > 0 && mc_delta_img != 16'(own_q[$] + 1)) in_err++;
      vpos++;
    end else begin
      if (pv) vlen_q.push_back(cyc - v_rise);
      if ((mc_x_real | mc_delta_real | mc_delta_img) != '0) zero_err++;
    end
    pv = mc_in_valid;
    if (rsp_valid) begin
      if (rpos == 0) rid_q.push_back(int'(rsp_id));
      else if (int'(rsp_id) != rid_q[$]) r_err++;
      if (rsp_y_real != 16'(rpos) + 16'h4000 || rsp_y_img != ~16'(rpos)) r_err++;
      r_cnt++;
      if (rsp_last) begin rlen_q.push_back(rpos + 1); rlast_q.push_back(cyc); rpos = 0; end
      else rpos++;
    end else if (rsp_last) r_err++;
    if (int'(outstanding) > out_peak) out_peak = int'(outstanding);
  end

  // observation of u_gap grants
  int gg_own_q[$], gg_len_q[$], gg_idle_q[$];
  int gg_rise = 0, gg_fall = -1;
  logic [NR-1:0] gpg = '0;
  initial forever begin
    @(negedge clk);
    if (!rst_n) gg_fall = -1;
    if (g_grant != '0 && gpg == '0) begin
      gg_own_q.push_back(g_grant[1] ? 1 : 0);
      if (gg_fall >= 0) gg_idle_q.push_back(cyc - gg_fall);
      gg_rise = cyc;
    end
    if (g_grant == '0 && gpg != '0) begin
      gg_len_q.push_back(cyc - gg_rise);
      gg_fall = cyc;
    end
    gpg = g_grant;
  end

  int seen, snap;
  initial begin
    rst_n = 1'b0; mc_out_valid = 1'b0; mc_y_real = '0; mc_y_img = '0; g_req_valid = '0;
    wait_cyc(3);
    chk("rst_grant", 32'(req_grant), 0);
    chk("rst_in_valid", 32'(mc_in_valid), 0);
    chk("rst_x_real", 32'(mc_x_real), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_outstanding", 32'(outstanding), 0);
    chk("rst_errs", 32'({err_orphan, err_proto}), 0);

    // single frame from requester 0
    rst_n = 1'b1;
    frames_left[0] = 1;
    wait_cyc(270);
    chk("t1_bursts", own_q.size(), 1);
    chk("t1_owner", own_q[0], 0);
    chk("t1_grant_len", glen_q[0], FL);
    chk("t1_valid_len", vlen_q[0], FL);
    chk("t1_valid_lag", vrise_q[0] - grise_q[0], 1);
    chk("t1_in_data_err", in_err, 0);
    chk("t1_idle_zero_err", zero_err, 0);
    chk("t1_outstanding", 32'(outstanding), 1);
    mc_frame();
    wait_cyc(3);
    chk("t1_rsp_frames", rid_q.size(), 1);
    chk("t1_rsp_id", rid_q[0], 0);
    chk("t1_rsp_last_pos", rlen_q[0], FL);
    chk("t1_rsp_count", r_cnt, FL);
    chk("t1_rsp_err", r_err, 0);
    chk("t1_outstanding_end", 32'(outstanding), 0);

    // both requesters pending at reset release
    rst_n = 1'b0;
    frames_left[0] = 1; frames_left[1] = 1;
    wait_cyc(2);
    own_q.delete(); glen_q.delete(); gidle_q.delete(); grise_q.delete();
    rid_q.delete(); rlen_q.delete(); rlast_q.delete(); out_peak = 0;
    rst_n = 1'b1;
    wait_cyc(530);
    chk("t2_owner0", own_q[0], 0);
    chk("t2_owner1", own_q[1], 1);
    chk("t2_bubble", gidle_q[0], 1);
    chk("t2_peak", out_peak, 2);
    mc_frame();
    mc_frame();
    wait_cyc(3);
    chk("t2_rsp_id0", rid_q[0], 0);
    chk("t2_rsp_id1", rid_q[1], 1);
    chk("t2_rsp_len1", rlen_q[1], FL);
    chk("t2_outstanding_end", 32'(outstanding), 0);

    // MAX_OUT=2: third frame from requester 1 waits for the first rsp_last
    own_q.delete(); grise_q.delete(); rid_q.delete(); rlen_q.delete(); rlast_q.delete();
    frames_left[1] = 3;
    wait_cyc(800);
    chk("t3_withheld_bursts", own_q.size(), 2);
    chk("t3_withheld_grant", 32'(req_grant), 0);
    chk("t3_full_outstanding", 32'(outstanding), 2);
    mc_frame();
    wait_cyc(5);
    chk("t3_release_timing", grise_q[2] - rlast_q[0], 1);
    wait_cyc(260);
    mc_frame();
    mc_frame();
    wait_cyc(3);
    chk("t3_total_bursts", own_q.size(), 3);
    chk("t3_rsp_ids", rid_q[0] + rid_q[1] + rid_q[2], 3);
    chk("t3_outstanding_end", 32'(outstanding), 0);
    chk("t3_in_data_err", in_err, 0);
    chk("t3_rsp_err", r_err, 0);

    // GAP_CYCLES=3 instance with continuous requests
    g_req_valid = 2'b11;
    wait_cyc(800);
    chk("t4_gap_len", gg_len_q[0], FL);
    chk("t4_gap_idle0", gg_idle_q[0], 4);
    chk("t4_gap_idle1", gg_idle_q[1], 4);
    chk("t4_gap_order", gg_own_q[0] * 4 + gg_own_q[1] * 2 + gg_own_q[2], 2);

    // orphan frame with nothing issued
    snap = r_cnt;
    mc_frame();
    wait_cyc(3);
    chk("t5_orphan_flag", 32'(err_orphan), 1);
    chk("t5_orphan_dropped", r_cnt - snap, 0);
    chk("t5_orphan_outstanding", 32'(outstanding), 0);
    chk("t5_proto_clean", 32'(err_proto), 0);
    chk("t5_onehot_err", onehot_err, 0);

    // reset in the middle of a burst from requester 0
    frames_left[0] = 1;
    seen = 0;
    for (int t = 0; t < 400 && seen < 101; t++) begin
      @(negedge clk);
      if (req_grant[0]) seen++;
    end
    chk("t6_burst_reached", seen, 101);
    rst_n = 1'b0;
    @(negedge clk);
    chk("t6_rst_grant", 32'(req_grant), 0);
    chk("t6_rst_in_valid", 32'(mc_in_valid), 0);
    chk("t6_rst_outstanding", 32'(outstanding), 0);
    chk("t6_rst_orphan", 32'(err_orphan), 0);
    rst_n = 1'b1;
    wait_cyc(2);
    own_q.delete();
    frames_left[0] = 1; frames_left[1] = 1;
    wait_cyc(600);
    chk("t6_restart_owner0", own_q[0], 0);
    chk("t6_restart_owner1", own_q[1], 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
